// File: rtl/aes_pkg.sv
// Shared AES definitions: round-key geometry, key-schedule FSM states and GF(2^8) xtime.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef logic [3:0] aes_round_t;

    localparam aes_round_t AES_LAST_ROUND = 4'(AES_NR);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        MIX
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared by the key schedule and the SubBytes stage.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the top byte, so row 0 of the table is the leftmost literal.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] w_table [0:255];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_table
            assign w_table[gi] = SBOX_TABLE[2047 - 8*gi -: 8];
        end
    endgenerate

    assign o_byte = w_table[i_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one time-shared S-box, 5 cycles per round, 11 stored round keys.
// Defining AES_KEY_SCHED_ZEROIZE_EN adds the key_zeroize input that wipes all key material.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_load,
    input  logic [AES_KEY_W-1:0] key_in,
    input  aes_round_t           round_sel,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    input  logic                 key_zeroize,
`endif
    output logic [AES_KEY_W-1:0] round_key,
    output logic                 key_busy,
    output logic                 key_ready
);

    ks_state_t            r_state;
    ks_state_t            w_state_next;
    logic [AES_KEY_W-1:0] r_key_store [0:AES_NR];
    logic [AES_KEY_W-1:0] r_cur_key;
    logic [AES_KEY_W-1:0] w_new_key;
    logic [AES_KEY_W-1:0] w_store_wdata;
    logic [AES_NR:0]      w_store_we;
    logic [31:0]          r_sub_word;
    logic [31:0]          w_w4;
    logic [31:0]          w_w5;
    logic [31:0]          w_w6;
    logic [31:0]          w_w7;
    logic [7:0]           r_rcon;
    logic [7:0]           w_rot_byte;
    logic [7:0]           w_sub_byte;
    aes_round_t           r_rnd;
    logic [1:0]           r_byte_cnt;
    logic                 w_zeroize;
    logic                 w_load_go;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign w_zeroize = key_zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_load_go = (r_state == IDLE) && key_load && !w_zeroize;

    // RotWord folded into the byte select: byte 0 of RotWord(w3) is w3[23:16].
    always_comb begin
        w_rot_byte = r_cur_key[23:16];
        case (r_byte_cnt)
            2'd0:    w_rot_byte = r_cur_key[23:16];
            2'd1:    w_rot_byte = r_cur_key[15:8];
            2'd2:    w_rot_byte = r_cur_key[7:0];
            2'd3:    w_rot_byte = r_cur_key[31:24];
            default: w_rot_byte = r_cur_key[23:16];
        endcase
    end

    aes_sbox u_sbox (
        .i_byte (w_rot_byte),
        .o_byte (w_sub_byte)
    );

    assign w_w4      = r_cur_key[127:96] ^ r_sub_word ^ {r_rcon, 24'h0};
    assign w_w5      = r_cur_key[95:64] ^ w_w4;
    assign w_w6      = r_cur_key[63:32] ^ w_w5;
    assign w_w7      = r_cur_key[31:0] ^ w_w6;
    assign w_new_key = {w_w4, w_w5, w_w6, w_w7};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (key_load) w_state_next = SUB;
            SUB:     if (r_byte_cnt == 2'd3) w_state_next = MIX;
            MIX:     w_state_next = (r_rnd == AES_LAST_ROUND) ? IDLE : SUB;
            default: w_state_next = IDLE;
        endcase
        if (w_zeroize) begin
            w_state_next = IDLE;
        end
    end

    assign w_store_wdata = (r_state == IDLE) ? key_in : w_new_key;

    genvar gi;
    generate
        for (gi = 0; gi <= AES_NR; gi++) begin : g_store
            if (gi == 0) begin : g_we_load
                assign w_store_we[gi] = w_load_go;
            end else begin : g_we_mix
                assign w_store_we[gi] = (r_state == MIX) && (r_rnd == 4'(gi));
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_key_store[gi] <= '0;
                end else if (w_zeroize) begin
                    r_key_store[gi] <= '0;
                end else if (w_store_we[gi]) begin
                    r_key_store[gi] <= w_store_wdata;
                end
            end
        end
    endgenerate

    // r_cur_key shadows key_store[rnd-1] so the round logic never needs an 11:1 read mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_key  <= '0;
            r_sub_word <= '0;
            r_rcon     <= 8'h01;
            r_rnd      <= '0;
            r_byte_cnt <= '0;
            round_key  <= '0;
            key_busy   <= 1'b0;
            key_ready  <= 1'b0;
        end else if (w_zeroize) begin
            r_cur_key  <= '0;
            r_sub_word <= '0;
            r_rcon     <= 8'h01;
            r_rnd      <= '0;
            r_byte_cnt <= '0;
            round_key  <= '0;
            key_busy   <= 1'b0;
            key_ready  <= 1'b0;
        end else begin
            round_key <= (round_sel <= AES_LAST_ROUND) ? r_key_store[round_sel] : '0;
            case (r_state)
                IDLE: begin
                    if (key_load) begin
                        r_cur_key  <= key_in;
                        r_rcon     <= 8'h01;
                        r_rnd      <= 4'd1;
                        r_byte_cnt <= '0;
                        key_busy   <= 1'b1;
                        key_ready  <= 1'b0;
                    end
                end
                SUB: begin
                    r_sub_word <= {r_sub_word[23:0], w_sub_byte};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                MIX: begin
                    r_cur_key <= w_new_key;
                    if (r_rnd == AES_LAST_ROUND) begin
                        key_busy  <= 1'b0;
                        key_ready <= 1'b1;
                    end else begin
                        r_rnd  <= r_rnd + 4'd1;
                        r_rcon <= xtime(r_rcon);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule; read results are scored through an expected-value queue.
module tb_aes_key_schedule;

    logic         clk;
    logic         reset_n;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   round_sel;
    logic [127:0] round_key;
    logic         key_busy;
    logic         key_ready;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic         key_zeroize;
`endif

    aes_key_schedule dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_load    (key_load),
        .key_in      (key_in),
        .round_sel   (round_sel),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        .key_zeroize (key_zeroize),
`endif
        .round_key   (round_key),
        .key_busy    (key_busy),
        .key_ready   (key_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        string        tag;
        logic [127:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_vec  = 0;
    int        n_miss = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Drive a select, queue its expected key, then score the DUT output one cycle later.
    task automatic rd(input logic [3:0] sel, input logic [127:0] exp, input string tag);
        sb_entry_t e;
        round_sel = sel;
        sb_q.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 128'd1, 128'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, round_key, e.exp);
            $display("read %-18s sel=%0d key=%h", e.tag, sel, round_key);
        end
    endtask

    task automatic start_load(input logic [127:0] key, input string tag);
        key_in   = key;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        check({tag, "_busy_at_E0"}, 128'(key_busy), 128'd1);
        check({tag, "_ready_at_E0"}, 128'(key_ready), 128'd0);
        $display("load %-18s key=%h", tag, key);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 49) begin
                check({tag, "_busy_E49"}, 128'(key_busy), 128'd1);
                check({tag, "_ready_E49"}, 128'(key_ready), 128'd0);
            end
            if (k == 50) begin
                check({tag, "_busy_E50"}, 128'(key_busy), 128'd0);
                check({tag, "_ready_E50"}, 128'(key_ready), 128'd1);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        round_sel = '0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        key_zeroize = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_round_key", round_key, 128'd0);
        check("reset_busy", 128'(key_busy), 128'd0);
        check("reset_ready", 128'(key_ready), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // FIPS-197 expansion with an ignored zero-key pulse sampled at E0+20.
        round_sel = 4'd1;
        start_load(K_FIPS, "fips");
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 5)  check("rk1_old_at_write", round_key, 128'd0);
            if (k == 6)  check("rk1_new_after_write", round_key, FIPS_RK[1]);
            if (k == 19) begin
                key_in   = '0;
                key_load = 1'b1;
            end
            if (k == 20) key_load = 1'b0;
            if (k == 49) begin
                check("fips_busy_E49", 128'(key_busy), 128'd1);
                check("fips_ready_E49", 128'(key_ready), 128'd0);
            end
            if (k == 50) begin
                check("fips_busy_E50", 128'(key_busy), 128'd0);
                check("fips_ready_E50", 128'(key_ready), 128'd1);
            end
        end
        for (int r = 0; r <= 10; r++) begin
            rd(4'(r), FIPS_RK[r], $sformatf("fips_rk%0d", r));
        end
        rd(4'd11, 128'd0, "sel11_zero");
        rd(4'd15, 128'd0, "sel15_zero");
        rd(4'd10, FIPS_RK[10], "sel10_after_oob");

        // Zero key, with key_load held across E0+50 for a back-to-back reload.
        start_load(128'd0, "zero");
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            if (k == 49) key_load = 1'b1;
            if (k == 50) begin
                check("b2b_ready_E50", 128'(key_ready), 128'd1);
                check("b2b_busy_E50", 128'(key_busy), 128'd0);
            end
            if (k == 51) begin
                key_load = 1'b0;
                check("b2b_ready_E51", 128'(key_ready), 128'd0);
                check("b2b_busy_E51", 128'(key_busy), 128'd1);
            end
            if (k == 100) check("b2b_ready_E100", 128'(key_ready), 128'd0);
            if (k == 101) check("b2b_ready_E101", 128'(key_ready), 128'd1);
        end
        rd(4'd0, 128'd0, "zero_rk0");
        rd(4'd1, Z_RK1, "zero_rk1");
        rd(4'd10, Z_RK10, "zero_rk10");

        // Asynchronous reset in the middle of a FIPS expansion.
        round_sel = 4'd10;
        start_load(K_FIPS, "rst_mid");
        repeat (22) @(negedge clk);
        check("pre_reset_rk10", round_key, Z_RK10);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_round_key", round_key, 128'd0);
        check("async_rst_busy", 128'(key_busy), 128'd0);
        check("async_rst_ready", 128'(key_ready), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(4'd10, 128'd0, "post_reset_rk10");
        repeat (5) @(negedge clk);
        check("post_reset_idle_busy", 128'(key_busy), 128'd0);
        start_load(K_FIPS, "fips_again");
        wait_done("fips_again");
        rd(4'd1, FIPS_RK[1], "fips2_rk1");
        rd(4'd5, FIPS_RK[5], "fips2_rk5");
        rd(4'd10, FIPS_RK[10], "fips2_rk10");

`ifdef AES_KEY_SCHED_ZEROIZE_EN
        round_sel   = 4'd10;
        key_zeroize = 1'b1;
        @(negedge clk);
        key_zeroize = 1'b0;
        check("zeroize_ready", 128'(key_ready), 128'd0);
        check("zeroize_round_key", round_key, 128'd0);
        rd(4'd10, 128'd0, "zeroize_rk10");
        rd(4'd0, 128'd0, "zeroize_rk0");
        key_in      = K_FIPS;
        key_load    = 1'b1;
        key_zeroize = 1'b1;
        @(negedge clk);
        key_load    = 1'b0;
        key_zeroize = 1'b0;
        check("zeroize_load_busy", 128'(key_busy), 128'd0);
        repeat (10) @(negedge clk);
        check("zeroize_load_busy_later", 128'(key_busy), 128'd0);
        rd(4'd0, 128'd0, "zeroize_load_rk0");
`endif

        if (sb_q.size() != 0) begin
            check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
